// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Accepts one ALU command per handshake, serialises it onto the ALU's
// opcode_valid/opcode/data bus as an OP_WIDTH-cycle frame, waits for the ALU
// done strobe (or a timeout), and returns the captured result on a
// valid/ready response port. Commands are not overlapped: a new command is
// accepted only after the previous response has been consumed.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Valid never depends on ready, and a producer holding
// valid high keeps its payload stable until the transfer edge.
//
// Optional feature macro: ALU_SEQ_STATS_EN builds the stat_cmds and
// stat_timeouts counters; without it both ports are tied to zero.
//
// The FSM state is held in the enum register 'state' for checker binding.

module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic [15:0]           stat_cmds,
  output logic [15:0]           stat_timeouts
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Frame bit counter and wait counter widths.
  localparam int KW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(OP_WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  state_t                  state;
  logic [KW-1:0]           k;         // index of the opcode bit currently on the bus
  logic [CW-1:0]           wait_cnt;  // cycles spent in WAIT, starting at 0
  logic [OP_WIDTH-1:0]     op_sh;     // remaining opcode bits, next bit in [0]
  logic [DATA_WIDTH-1:0]   b_q;       // operand B, sent on the second frame cycle
  logic                    accept;
  logic                    timeout_hit;

  assign cmd_ready   = (state == IDLE) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (state == WAIT) && !done && (wait_cnt == C_LAST);

  // Main sequencer FSM: frame serialisation, response capture and timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      wait_cnt     <= '0;
      op_sh        <= '0;
      b_q          <= '0;
      opcode_valid <= 1'b0;
      opcode       <= 1'b0;
      data         <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // First frame cycle carries op[0] and operand A.
            state        <= SEND;
            k            <= '0;
            op_sh        <= cmd_op >> 1;
            b_q          <= cmd_b;
            opcode_valid <= 1'b1;
            opcode       <= cmd_op[0];
            data         <= cmd_a;
          end
        end
        SEND: begin
          // A done strobe during the frame is deliberately ignored.
          if (k == K_LAST) begin
            state        <= WAIT;
            wait_cnt     <= '0;
            opcode_valid <= 1'b0;
            opcode       <= 1'b0;
            data         <= '0;
          end else begin
            k      <= k + KW'(1);
            opcode <= op_sh[0];
            op_sh  <= op_sh >> 1;
            data   <= (k == '0) ? b_q : '0;
          end
        end
        WAIT: begin
          // done on the final counted edge still wins over the timeout.
          if (done) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_result   <= result;
            rsp_overflow <= overflow;
            rsp_timeout  <= 1'b0;
          end else if (wait_cnt == C_LAST) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          // Response fields hold until the consumer takes them.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Free-running wrap-around counters of accepted commands and timeouts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cmds     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (accept) begin
        stat_cmds <= stat_cmds + 16'd1;
      end
      if (timeout_hit) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`else
  assign stat_cmds     = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer: reset behaviour, frame
// serialisation, response capture, backpressure, timeout and stats.

module tb_alu_cmd_sequencer;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int TO = 64;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          opcode_valid;
  logic          opcode;
  logic [DW-1:0] data;
  logic          done;
  logic [DW-1:0] result;
  logic          overflow;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow;
  logic          rsp_timeout;
  logic [15:0]   stat_cmds;
  logic [15:0]   stat_timeouts;

  int checks   = 0;
  int failures = 0;

  alu_cmd_sequencer #(
    .DATA_WIDTH (DW),
    .OP_WIDTH   (OW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .opcode_valid  (opcode_valid),
    .opcode        (opcode),
    .data          (data),
    .done          (done),
    .result        (result),
    .overflow      (overflow),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_timeout   (rsp_timeout),
    .stat_cmds     (stat_cmds),
    .stat_timeouts (stat_timeouts)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command and hold it until the accepting edge has passed.
  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic ok;
    ok        = 1'b0;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    check("issue_accepted", 32'(ok), 32'd1);
  endtask

  // Called in the first SEND cycle; checks the whole frame and ends in the
  // first WAIT cycle. Optionally strobes done during the second frame cycle.
  task automatic frame_check(input logic [OW-1:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic glitch);
    logic [DW-1:0] exp_data;
    for (int i = 0; i < OW; i++) begin
      exp_data = (i == 0) ? a : ((i == 1) ? b : '0);
      check("frame_valid",  32'(opcode_valid), 32'd1);
      check("frame_opcode", 32'(opcode),       32'(op[i]));
      check("frame_data",   32'(data),         32'(exp_data));
      if (glitch && i == 1) begin
        done     = 1'b1;
        result   = 8'h99;
        overflow = 1'b1;
      end
      step();
      done     = 1'b0;
      overflow = 1'b0;
    end
    check("wait_valid_low",  32'(opcode_valid), 32'd0);
    check("wait_opcode_low", 32'(opcode),       32'd0);
    check("wait_data_low",   32'(data),         32'd0);
    check("wait_no_rsp",     32'(rsp_valid),    32'd0);
  endtask

  // ALU model: pulse done in the delay-th WAIT cycle (1 = first WAIT cycle).
  task automatic alu_done(input int delay, input logic [DW-1:0] res, input logic ovf);
    repeat (delay - 1) step();
    done     = 1'b1;
    result   = res;
    overflow = ovf;
    step();
    done     = 1'b0;
    overflow = 1'b0;
  endtask

  task automatic check_rsp(input logic [DW-1:0] res, input logic ovf, input logic tmo);
    check("rsp_valid",    32'(rsp_valid),    32'd1);
    check("rsp_result",   32'(rsp_result),   32'(res));
    check("rsp_overflow", 32'(rsp_overflow), 32'(ovf));
    check("rsp_timeout",  32'(rsp_timeout),  32'(tmo));
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("consume_rsp_low",   32'(rsp_valid), 32'd0);
    check("consume_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    done      = 1'b0;
    result    = '0;
    overflow  = 1'b0;
    rsp_ready = 1'b0;

    // Power-on reset.
    repeat (2) step();
    check("reset_cmd_ready", 32'(cmd_ready),    32'd0);
    check("reset_opv",       32'(opcode_valid), 32'd0);
    check("reset_data",      32'(data),         32'd0);
    check("reset_rsp_valid", 32'(rsp_valid),    32'd0);
    check("reset_rsp_res",   32'(rsp_result),   32'd0);
    reset = 1'b0;
    step();
    check("post_reset_ready", 32'(cmd_ready), 32'd1);

    // Test 1: reset held 3 cycles in the middle of a frame.
    issue(3'b101, 8'h12, 8'h34);
    check("t1_frame_started", 32'(opcode_valid), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_reset_opv",   32'(opcode_valid), 32'd0);
      check("t1_reset_ready", 32'(cmd_ready),    32'd0);
      check("t1_reset_rsp",   32'(rsp_valid),    32'd0);
    end
    reset = 1'b0;
    #1;
    check("t1_release_ready", 32'(cmd_ready), 32'd1);
    step();
    check("t1_idle_opv", 32'(opcode_valid), 32'd0);
    check("t1_idle_rsp", 32'(rsp_valid),    32'd0);

    // Test 2: normal command, done 2 cycles after the frame.
    issue(3'b101, 8'h12, 8'h34);
    frame_check(3'b101, 8'h12, 8'h34, 1'b0);
    alu_done(2, 8'h46, 1'b0);
    check_rsp(8'h46, 1'b0, 1'b0);

    // Test 5: backpressure with a stray done and a pending command.
    cmd_op    = 3'b001;
    cmd_a     = 8'hF0;
    cmd_b     = 8'h20;
    cmd_valid = 1'b1;
    done      = 1'b1;
    result    = 8'hAA;
    overflow  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      done     = 1'b0;
      overflow = 1'b0;
      check("t5_hold_valid",  32'(rsp_valid),    32'd1);
      check("t5_hold_result", 32'(rsp_result),   32'h46);
      check("t5_hold_ovf",    32'(rsp_overflow), 32'd0);
      check("t5_no_ready",    32'(cmd_ready),    32'd0);
      check("t5_no_frame",    32'(opcode_valid), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t5_rsp_taken", 32'(rsp_valid),    32'd0);
    check("t5_ready_now", 32'(cmd_ready),    32'd1);
    check("t5_no_frame2", 32'(opcode_valid), 32'd0);
    step();
    cmd_valid = 1'b0;

    // Test 3: frame starts right after acceptance; overflow response.
    frame_check(3'b001, 8'hF0, 8'h20, 1'b0);
    alu_done(1, 8'h10, 1'b1);
    check_rsp(8'h10, 1'b1, 1'b0);
    consume();

    // Test 4: ALU never answers.
    issue(3'b110, 8'h01, 8'h02);
    frame_check(3'b110, 8'h01, 8'h02, 1'b0);
    n = 1;
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      step();
      if (!rsp_valid) n++;
    end
    check("t4_wait_cycles", 32'(n), 32'd64);
    check_rsp(8'h00, 1'b0, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    check("t4_stat_timeouts", 32'(stat_timeouts), 32'd1);
`else
    check("t4_stat_timeouts_off", 32'(stat_timeouts), 32'd0);
`endif
    consume();

    // Test 6: done during SEND is ignored; real done in WAIT.
    issue(3'b011, 8'h55, 8'h66);
    frame_check(3'b011, 8'h55, 8'h66, 1'b1);
    alu_done(2, 8'h77, 1'b0);
    check_rsp(8'h77, 1'b0, 1'b0);
    consume();

    // Stats: fresh reset, then 3 back-to-back commands.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("stat_cmds_cleared",     32'(stat_cmds),     32'd0);
    check("stat_timeouts_cleared", 32'(stat_timeouts), 32'd0);
    issue(3'b010, 8'h01, 8'h11);
    frame_check(3'b010, 8'h01, 8'h11, 1'b0);
    alu_done(1, 8'h21, 1'b0);
    check_rsp(8'h21, 1'b0, 1'b0);
    consume();
    issue(3'b100, 8'h02, 8'h22);
    frame_check(3'b100, 8'h02, 8'h22, 1'b0);
    alu_done(1, 8'h42, 1'b1);
    check_rsp(8'h42, 1'b1, 1'b0);
    consume();
    issue(3'b111, 8'h03, 8'h33);
    frame_check(3'b111, 8'h03, 8'h33, 1'b0);
    alu_done(1, 8'h63, 1'b0);
    check_rsp(8'h63, 1'b0, 1'b0);
    consume();
`ifdef ALU_SEQ_STATS_EN
    check("stat_cmds_three",  32'(stat_cmds),     32'd3);
    check("stat_timeouts_0",  32'(stat_timeouts), 32'd0);
`else
    check("stat_cmds_off",    32'(stat_cmds),     32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream driver for the simple ALU stage. It accepts one whole command per handshake (3-bit op, operands A and B) and serialises it onto the ALU's opcode_valid/opcode/data bus as a 3-cycle frame. It then waits for the ALU's done pulse, captures result/overflow, and returns them on a valid/ready response port. A timeout guards against an ALU that never responds.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU.
OP_WIDTH, 3, opcode bits; equals the frame length in cycles, minimum 2.
TIMEOUT, 64, max cycles in WAIT before a timeout response; minimum 1.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  OP_WIDTH  ALU opcode
cmd_a  input  DATA_WIDTH  operand A
cmd_b  input  DATA_WIDTH  operand B
opcode_valid  output  1  ALU frame cycle active
opcode  output  1  serial opcode bit, LSB first
data  output  DATA_WIDTH  ALU data bus
done  input  1  ALU completion strobe
result  input  DATA_WIDTH  ALU result, valid with done
overflow  input  1  ALU overflow, valid with done
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  DATA_WIDTH  captured result
rsp_overflow  output  1  captured overflow
rsp_timeout  output  1  response was produced by timeout
stat_cmds  output  16  accepted-command count (optional feature)
stat_timeouts  output  16  timeout count (optional feature)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset: sampled only on a clk rising edge.
- While reset is high, or in the cycle after it is released:
  - state=IDLE;
  - opcode_valid=0, opcode=0, data=0;
  - rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_timeout=0;
  - cmd_ready=0 while reset is high.
- All outputs are registered except cmd_ready, which equals (state==IDLE && !reset).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge T, latch op/a/b and go to SEND with bit counter k=0.
- SEND lasts OP_WIDTH cycles; the first SEND cycle is the cycle after T.
  - Each cycle: opcode_valid=1, opcode=op[k].
  - data = a when k=0, b when k=1, 0 when k>=2.
  - After k=OP_WIDTH-1 go to WAIT. opcode_valid is then 0, data 0, opcode 0.
- done seen during SEND is ignored: no capture, no error.
- WAIT:
  - A wait counter starts at 0 and increments every cycle.
  - On the first edge with done=1: capture result into rsp_result and overflow into rsp_overflow, set rsp_timeout=0, rsp_valid=1, go to RESP.
  - If the counter reaches TIMEOUT-1 with done=0: rsp_result=0, rsp_overflow=0, rsp_timeout=1, rsp_valid=1, go to RESP.
  - If done=1 on that same final edge, done wins and it is a normal response.
- RESP:
  - rsp_* are held stable while rsp_valid=1 && !rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE. cmd_ready is 1 the following cycle.
  - done pulses arriving in RESP or IDLE are ignored.
- Throughput: one command per OP_WIDTH+1+latency(ALU)+1 cycles minimum. There is no overlap: a new frame never starts before the previous response is consumed.
- Reset mid-frame or mid-wait: abandon the operation. No response is produced, and opcode_valid drops in the reset cycle.

Optional Feature:
ALU_SEQ_STATS_EN:
- Defined:
  - stat_cmds increments on each accepted command.
  - stat_timeouts increments on each timeout response.
  - Both are 16-bit, wrap 0xFFFF->0x0000, and are cleared by reset.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
1. Reset held 3 cycles mid-SEND, then released -> opcode_valid=0 in the reset cycles; rsp_valid=0; cmd_ready=1 the first cycle after release.
2. cmd op=3'b101, a=0x12, b=0x34; ALU model pulses done 2 cycles after the frame with result=0x46, overflow=0:
   - frame is (valid,opcode,data) = (1,1,0x12), (1,0,0x34), (1,1,0x00);
   - then rsp_valid=1, rsp_result=0x46, rsp_overflow=0, rsp_timeout=0.
3. op=3'b001, a=0xF0, b=0x20; ALU returns result=0x10, overflow=1 -> rsp_overflow=1, rsp_result=0x10.
4. TIMEOUT=64; ALU never asserts done -> exactly 64 WAIT cycles, then rsp_valid=1, rsp_timeout=1, rsp_result=0. With ALU_SEQ_STATS_EN: stat_timeouts=1.
5. rsp_ready held 0 for 5 cycles in RESP while done pulses again with result=0xAA and cmd_valid stays high -> rsp_result stays 0x46, cmd_ready=0, no new frame. After rsp_ready=1, the next frame starts 1 cycle after acceptance.
6. done asserted during SEND cycle 2, then a real done in WAIT with 0x77 -> SEND-cycle done is ignored; rsp_result=0x77. With stats: 3 back-to-back commands give stat_cmds=3.
